iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider_pkg.sv | 12 +
 rtl/iter_divider_if.sv | 43 ++++
 rtl/iter_divider_trial_sub.sv | 14 +
 rtl/iter_divider.sv | 139 +++++++++++++
 tb/tb_iter_divider.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package iter_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle of the divider; the dz flag exists only when DIV_ZERO_CHK_EN is defined.
interface iter_divider_if
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // start is sampled only while the divider is idle; done is a one-cycle
  // pulse and quotient/remainder stay valid from it until the next done.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_CHK_EN
  logic             dz;
`endif

`ifdef DIV_ZERO_CHK_EN
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif

endinterface

// File: rtl/iter_divider_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor; the difference sign says whether to restore.
module trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           neg
);

  assign diff = minuend - subtrahend;
  assign neg  = diff[WIDTH];

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Optional feature: DIV_ZERO_CHK_EN short-circuits divide-by-zero and adds the dz flag.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  iter_divider_if.slave bus,
  output state_t dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   prem_next;
  logic             neg;
  logic             last_iter;
  logic             div_zero;
  logic             busy;
  logic             done;

`ifdef DIV_ZERO_CHK_EN
  logic dz_r;
  assign div_zero = (bus.divisor == '0);
  assign bus.dz   = dz_r;
`else
  assign div_zero = 1'b0;
`endif

  // work holds the not-yet-consumed dividend bits at the top and the
  // quotient bits shifting in at the bottom.
  assign shifted   = (prem << 1) | {{WIDTH{1'b0}}, work[WIDTH-1]};
  assign prem_next = neg ? shifted : diff;
  assign work_next = {work[WIDTH-2:0], ~neg};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend    (shifted),
    .subtrahend ({1'b0, divisor_r}),
    .diff       (diff),
    .neg        (neg)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = div_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_BUSY: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      divisor_r <= '0;
      work      <= '0;
      prem      <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
`ifdef DIV_ZERO_CHK_EN
      dz_r      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            divisor_r <= bus.divisor;
            work      <= bus.dividend;
            prem      <= '0;
            count     <= '0;
`ifdef DIV_ZERO_CHK_EN
            // Zero divisor skips the iterations but reports the same
            // result the full restoring loop would produce.
            if (div_zero) begin
              quot_r <= '1;
              rem_r  <= bus.dividend;
              dz_r   <= 1'b1;
            end
`endif
          end
        end
        ST_BUSY: begin
          prem  <= prem_next;
          work  <= work_next;
          count <= count + 1'b1;
          if (last_iter) begin
            quot_r <= work_next;
            rem_r  <= prem_next[WIDTH-1:0];
          end
        end
        ST_DONE: begin
`ifdef DIV_ZERO_CHK_EN
          dz_r <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_iter_divider.sv
// Directed and random self-checking bench for iter_divider (8-bit build).
module tb_iter_divider;
  import iter_divider_pkg::*;

  localparam int W = 8;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles from the start-asserting cycle to the done cycle.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_CHK_EN
    if (b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Drives one division; optionally re-asserts start (10/2) poke_at cycles in.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input string tag, input int poke_at);
    int lat;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 || lat == poke_at + 1) begin
        bus.start    = 1'b0;
        bus.dividend = W'($urandom_range(0, 255));
        bus.divisor  = W'($urandom_range(0, 255));
      end
      if (poke_at > 0 && lat == poke_at) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd10;
        bus.divisor  = 8'd2;
      end
    end while (!bus.done && lat < 40);
    bus.start = 1'b0;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_lat"}, lat, exp_lat(b));
    check({tag, "_q"}, bus.quotient, exp_q.pop_front());
    check({tag, "_r"}, bus.remainder, exp_q.pop_front());
`ifdef DIV_ZERO_CHK_EN
    check({tag, "_dz"}, bus.dz, (b == '0) ? 1 : 0);
`endif
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_done_after"}, bus.done, 0);
  endtask

  initial begin
    int seen_done;
    logic [W-1:0] ra, rb, rq, rr;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef DIV_ZERO_CHK_EN
    check("rst_dz", bus.dz, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd200, 8'd7, 8'd28, 8'd4, "d200_7", 0);
    do_op(8'd255, 8'd1, 8'd255, 8'd0, "d255_1", 0);
    do_op(8'd5, 8'd9, 8'd0, 8'd5, "d5_9", 0);
    do_op(8'd0, 8'd3, 8'd0, 8'd0, "d0_3", 0);
    do_op(8'd100, 8'd3, 8'd33, 8'd1, "busy_start", 3);

    // Reset four cycles into a division: outputs clear, no done follows.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_q", bus.quotient, 0);
    check("mid_rst_r", bus.remainder, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("mid_rst_no_done", seen_done, 0);
    do_op(8'd9, 8'd4, 8'd2, 8'd1, "d9_4", 0);

    do_op(8'd77, 8'd0, 8'd255, 8'd77, "d77_0", 0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (rb == '0) begin
        rq = '1;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      do_op(ra, rb, rq, rr, "rand", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
